// File: rtl/ascon_host_pkg.sv
// Shared types and constants for the host-side Ascon hash serial driver.
package ascon_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DELAY,
        READ,
        DONE
    } state_e;

    // Galois mask for x^32 + x^22 + x^2 + x + 1 in right-shift form.
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2024;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ascon_lfsr32.sv
// 32-bit Galois LFSR supplying per-cycle randomness; advances only when enabled.
module ascon_lfsr32
    import ascon_host_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ascon_hash_host_if.sv
// Host driver for the serial Ascon hash core: loads message and randomness, starts the
// core, waits for ready, deserializes the hash and reports the measured latency.
module ascon_hash_host_if
    import ascon_host_pkg::*;
#(
    parameter int unsigned Y            = 40,
    parameter int unsigned H            = 256,
    parameter int unsigned L            = 256,
    parameter int unsigned START_CYCLES = 5,
    parameter int unsigned READ_DELAY   = 4,
    parameter logic [31:0] LFSR_SEED    = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [Y-1:0]  msg_i,
    output logic [2:0]    message_o,
    output logic [6:0]    r_64_o,
    output logic          r_fault_o,
    output logic          start_o,
    input  logic          ready_i,
    input  logic          hash_i,
    output logic [L-1:0]  hash_o,
    output logic [15:0]   latency_o,
    output logic          done_o,
    output logic          busy_o
);

    localparam int unsigned MAX = max3(H, Y, L);
    localparam int unsigned CW  = $clog2(max3(MAX, START_CYCLES, READ_DELAY) + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [Y-1:0]    msg_q, msg_d;
    logic [15:0]     lat_cnt_q, lat_cnt_d;
    logic [15:0]     latency_q, latency_d;
    logic [L-1:0]    hash_buf_q, hash_buf_d;
    logic [L-1:0]    hash_q, hash_d;
    logic            lfsr_en;
    logic [31:0]     lfsr_state;
    logic [21:0]     unused_lfsr_hi;

    ascon_lfsr32 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (lfsr_en),
        .state_o(lfsr_state)
    );

    assign unused_lfsr_hi = lfsr_state[31:10];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        msg_d      = msg_q;
        lat_cnt_d  = lat_cnt_q;
        latency_d  = latency_q;
        hash_buf_d = hash_buf_q;
        hash_d     = hash_q;
        lfsr_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    msg_d     = msg_i;
                    cnt_d     = '0;
                    lat_cnt_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                // Message leaves MSB first; zeros fill in once it is exhausted.
                lfsr_en = 1'b1;
                msg_d   = msg_q << 1;
                if (cnt_q == CW'(MAX - 1)) begin
                    cnt_d     = '0;
                    lat_cnt_d = 16'd1;
                    state_d   = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                lat_cnt_d = sat_inc16(lat_cnt_q);
                if (cnt_q == CW'(START_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                lat_cnt_d = sat_inc16(lat_cnt_q);
                if (ready_i) begin
                    latency_d = lat_cnt_q;
                    cnt_d     = '0;
                    state_d   = (READ_DELAY == 0) ? READ : DELAY;
                end
            end
            DELAY: begin
                if (cnt_q == CW'(READ_DELAY - 1)) begin
                    cnt_d   = '0;
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                // Shift in from the top so the first sample lands in bit 0 after L cycles;
                // hash_o only changes once the whole word is in.
                hash_buf_d = {hash_i, hash_buf_q[L-1:1]};
                if (cnt_q == CW'(L - 1)) begin
                    hash_d  = hash_buf_d;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            msg_q      <= '0;
            lat_cnt_q  <= '0;
            latency_q  <= '0;
            hash_buf_q <= '0;
            hash_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            msg_q      <= msg_d;
            lat_cnt_q  <= lat_cnt_d;
            latency_q  <= latency_d;
            hash_buf_q <= hash_buf_d;
            hash_q     <= hash_d;
        end
    end

    // Moore outputs decoded from registered state, so reset clears them without a clock.
    always_comb begin
        cmd_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        start_o     = (state_q == START);
        done_o      = (state_q == DONE);
        message_o   = '0;
        r_64_o      = '0;
        r_fault_o   = 1'b0;
        if (state_q == LOAD) begin
            message_o[0]                              = msg_q[Y-1];
            {r_fault_o, r_64_o, message_o[2:1]}       = lfsr_state[9:0];
        end
    end

    assign hash_o    = hash_q;
    assign latency_o = latency_q;

endmodule

// File: tb/tb_ascon_hash_host_if.sv
// Directed bench for ascon_hash_host_if with a behavioural core model and result scoreboard.
module tb_ascon_hash_host_if;

    localparam int Y            = 40;
    localparam int L            = 256;
    localparam int MAX          = 256;
    localparam int START_CYCLES = 5;
    localparam int READ_DELAY   = 4;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [Y-1:0]  msg_i = '0;
    logic [2:0]    message_o;
    logic [6:0]    r_64_o;
    logic          r_fault_o;
    logic          start_o;
    logic          ready_i = 1'b0;
    logic          hash_i = 1'b0;
    logic [L-1:0]  hash_o;
    logic [15:0]   latency_o;
    logic          done_o;
    logic          busy_o;

    always #5 clk = ~clk;

    ascon_hash_host_if dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .msg_i      (msg_i),
        .message_o  (message_o),
        .r_64_o     (r_64_o),
        .r_fault_o  (r_fault_o),
        .start_o    (start_o),
        .ready_i    (ready_i),
        .hash_i     (hash_i),
        .hash_o     (hash_o),
        .latency_o  (latency_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    typedef struct packed {
        logic [L-1:0] hash;
        logic [15:0]  lat;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [31:0]  m_lfsr = SEED;
    logic [L-1:0] prev_hash = '0;
    logic [15:0]  prev_lat = '0;

    task automatic check(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the IDLE negedge after DONE.
    task automatic run_txn(input logic [Y-1:0] msg, input int ready_after,
                           input logic [L-1:0] pat, input bit hold, input int abort_k);
        int          r;
        logic [15:0] new_lat;
        exp_t        e;
        bit          done_seen;
        logic        exp_bit;
        r       = (ready_after < START_CYCLES) ? START_CYCLES : ready_after;
        new_lat = 16'(r + 1);
        e.hash  = pat;
        e.lat   = new_lat;
        sb.push_back(e);

        cmd_valid_i = 1'b1;
        msg_i       = msg;
        #1;
        check("accept_ready", cmd_ready_o, 1'b1);
        @(negedge clk);
        if (!hold) cmd_valid_i = 1'b0;
        msg_i = ~msg;

        for (int k = 0; k < MAX; k++) begin
            #1;
            exp_bit = (k < Y) ? msg[Y-1-k] : 1'b0;
            check("load_msg_bit", message_o[0], exp_bit);
            check("load_rnd", {r_fault_o, r_64_o, message_o[2:1]}, m_lfsr[9:0]);
            check("load_ctrl", {cmd_ready_o, busy_o, start_o, done_o}, 4'b0100);
            check("load_hold_hash", hash_o, prev_hash);
            check("load_hold_lat", latency_o, prev_lat);
            if (k == abort_k) begin
                rst = 1'b0;
                #1;
                check("abort_outputs", {message_o, r_64_o, r_fault_o, start_o, done_o,
                                        busy_o, cmd_ready_o}, 15'd1);
                check("abort_hash", hash_o, '0);
                check("abort_lat", latency_o, 16'd0);
                void'(sb.pop_back());
                m_lfsr      = SEED;
                prev_hash   = '0;
                prev_lat    = '0;
                cmd_valid_i = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            m_lfsr = lfsr_step(m_lfsr);
            @(negedge clk);
        end

        done_seen = 1'b0;
        for (int n = 0; n < r + READ_DELAY + L + 16 && !done_seen; n++) begin
            ready_i = (n >= ready_after);
            hash_i  = (n > r + READ_DELAY && n <= r + READ_DELAY + L) ?
                      pat[n - r - READ_DELAY - 1] : 1'b0;
            #1;
            check("post_core_if", {message_o, r_64_o, r_fault_o}, 11'd0);
            check("post_start", start_o, (n < START_CYCLES));
            check("post_ctrl", {cmd_ready_o, busy_o}, 2'b01);
            check("post_lat", latency_o, (n <= r) ? prev_lat : new_lat);
            check("post_done", done_o, (n == r + READ_DELAY + L + 1));
            if (done_o) begin
                done_seen = 1'b1;
                check("sb_depth", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("done_hash", hash_o, e.hash);
                    check("done_lat", latency_o, e.lat);
                end
            end else begin
                check("post_hold_hash", hash_o, prev_hash);
            end
            @(negedge clk);
        end
        if (!done_seen) check("done_timeout", done_seen, 1'b1);

        ready_i = 1'b0;
        hash_i  = 1'b0;
        #1;
        check("idle_after_done", {cmd_ready_o, busy_o, done_o}, 3'b100);
        prev_hash = pat;
        prev_lat  = new_lat;
    endtask

    initial begin
        logic [L-1:0] p1, p2, p3, p4;
        p1 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'hA5A5_5A5A_0F0F_F0F0, 64'h1357_9BDF_2468_ACE0};
        p2 = {64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_FFFF_FFFF,
              64'h8000_0000_0000_0001, 64'h3C3C_C3C3_9696_6969};
        p3 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
              64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001};
        p4 = {64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_0000_1234_5678,
              64'h0BAD_C0DE_0BAD_C0DE, 64'hC001_D00D_8BAD_F00D};

        #2;
        check("reset_outputs", {message_o, r_64_o, r_fault_o, start_o, done_o, busy_o,
                                cmd_ready_o}, 15'd1);
        check("reset_hash", hash_o, '0);
        check("reset_lat", latency_o, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reference message, late core ready.
        run_txn(40'h6173636f6e, 100, p1, 1'b0, -1);
        // Ready already high when WAIT is entered; LFSR continues from where LOAD left it.
        run_txn(40'h0123456789, 0, p2, 1'b0, -1);
        // Reset in the middle of LOAD.
        run_txn(40'hDEADBEEFCA, 50, p3, 1'b0, 17);
        // Restart from seed with cmd_valid held across two back-to-back commands.
        run_txn(40'h5A5A5A5A5A, 20, p3, 1'b1, -1);
        run_txn(40'hFFFFFFFFFF, 7, p4, 1'b0, -1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
